// File: rtl/fixed_conv_pkg.sv
// rtl/fixed_conv_pkg.sv - shared field widths, bias, flag indices and encodings for the float-to-fixed converter
package fixed_conv_pkg;
    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam logic signed [9:0] EXP_BIAS = 10'sd127;
    localparam logic signed [9:0] EXP_MIN  = -10'sd126;

    localparam int FLAG_INV = 0;
    localparam int FLAG_OVF = 1;
    localparam int FLAG_UNF = 2;

    typedef enum logic {
        RND_TRUNC = 1'b0,
        RND_RNE   = 1'b1
    } rnd_mode_e;

    // K_OVF: finite operand whose leading bit already lands above the output range
    typedef enum logic [2:0] {
        K_ZERO,
        K_NORM,
        K_NAN,
        K_INF,
        K_OVF
    } kind_e;
endpackage

// File: rtl/fp_classify.sv
// rtl/fp_classify.sv - combinational binary32 class decode and unbiased exponent
module fp_classify
    import fixed_conv_pkg::*;
(
    input  logic              i_fp_bits_unused_guard,
    input  logic [31:0]       i_fp,
    output logic              o_sign,
    output logic              o_is_zero,
    output logic              o_is_sub,
    output logic              o_is_inf,
    output logic              o_is_nan,
    output logic signed [9:0] o_exp_unb
);
    logic [EXP_W-1:0] w_exp;
    logic [MAN_W-1:0] w_man;
    logic             w_exp_zero;
    logic             w_exp_ones;
    logic             w_man_zero;

    assign w_exp      = i_fp[MAN_W +: EXP_W];
    assign w_man      = i_fp[MAN_W-1:0];
    assign w_exp_zero = (w_exp == '0);
    assign w_exp_ones = &w_exp;
    assign w_man_zero = (w_man == '0);

    assign o_sign    = i_fp[MAN_W+EXP_W] ^ (i_fp_bits_unused_guard & 1'b0);
    assign o_is_zero = w_exp_zero & w_man_zero;
    assign o_is_sub  = w_exp_zero & ~w_man_zero;
    assign o_is_inf  = w_exp_ones & w_man_zero;
    assign o_is_nan  = w_exp_ones & ~w_man_zero;

    // Subnormals share the smallest normal exponent; only the hidden bit differs
    assign o_exp_unb = w_exp_zero ? EXP_MIN : ($signed({2'b00, w_exp}) - EXP_BIAS);
endmodule

// File: rtl/fp_to_fixed_pipe.sv
// rtl/fp_to_fixed_pipe.sv - binary32 to signed Q.F fixed point, two-stage valid/ready pipeline
module fp_to_fixed_pipe
    import fixed_conv_pkg::*;
#(
    parameter int Q = 2,
    parameter int F = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [31:0]    fp_in,
    input  logic           rnd_mode,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [Q+F-1:0] fx_out,
    output logic [2:0]     flags,
    output logic [2:0]     sticky_flags,
    input  logic           flags_clr
);
    localparam int W = Q + F;
    localparam logic [5:0]   D_MAX   = 6'(W + 1);
    localparam logic [W+1:0] V_ONE   = {{(W+1){1'b0}}, 1'b1};
    localparam logic [W:0]   POS_LIM = {2'b00, {(W-1){1'b1}}};
    localparam logic [W:0]   NEG_LIM = {2'b01, {(W-1){1'b0}}};
    localparam logic [W-1:0] SAT_POS = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] SAT_NEG = {1'b1, {(W-1){1'b0}}};

    logic              w_sign, w_is_zero, w_is_sub, w_is_inf, w_is_nan;
    logic signed [9:0] w_exp_unb;
    logic [23:0]       w_mant;
    logic signed [31:0] w_pos;
    logic [W+23:0]     w_ext;
    logic [W+1:0]      w_vec;
    logic [5:0]        w_dsh;
    kind_e             w_kind;
    logic              w_s1_adv;

    logic              r_s1_valid;
    logic              r_s1_sign;
    rnd_mode_e         r_s1_mode;
    kind_e             r_s1_kind;
    logic [W+1:0]      r_s1_vec;
    logic [5:0]        r_s1_dsh;

    logic              r_out_valid;
    logic [W-1:0]      r_fx;
    logic [2:0]        r_flags;
    logic [2:0]        r_sticky;

    fp_classify u_classify (
        .i_fp_bits_unused_guard (1'b0),
        .i_fp                   (fp_in),
        .o_sign                 (w_sign),
        .o_is_zero              (w_is_zero),
        .o_is_sub               (w_is_sub),
        .o_is_inf               (w_is_inf),
        .o_is_nan               (w_is_nan),
        .o_exp_unb              (w_exp_unb)
    );

    // w_pos is the output bit index where mantissa bit 23 lands; the W+1 bit window
    // spans indices W-1 down to -1 (guard), with everything below folded into bit 0
    assign w_mant = {~(w_is_zero | w_is_sub), fp_in[22:0]};
    assign w_pos  = 32'(w_exp_unb) + F;
    assign w_ext  = {w_mant, {W{1'b0}}};
    assign w_vec  = {w_ext[W+23:23], |w_ext[22:0]};
    assign w_dsh  = (w_pos < -1) ? D_MAX : 6'(W - 1 - w_pos);

    always_comb begin
        w_kind = K_NORM;
        if (w_is_nan)       w_kind = K_NAN;
        else if (w_is_inf)  w_kind = K_INF;
        else if (w_is_zero) w_kind = K_ZERO;
        else if (w_pos >= W) w_kind = K_OVF;
    end

    assign w_s1_adv = !r_out_valid || out_ready;
    assign in_ready = !r_s1_valid || w_s1_adv;

    always_ff @(posedge clk) begin
        if (rst)           r_s1_valid <= 1'b0;
        else if (in_ready) r_s1_valid <= in_valid;
        if (in_valid && in_ready) begin
            r_s1_sign <= w_sign;
            r_s1_mode <= rnd_mode_e'(rnd_mode);
            r_s1_kind <= w_kind;
            r_s1_vec  <= w_vec;
            r_s1_dsh  <= w_dsh;
        end
    end

    logic [W+1:0] w_shifted, w_mask;
    logic [W-1:0] w_mag;
    logic         w_guard, w_sticky, w_inc, w_rnd_ovf;
    logic [W:0]   w_mag_r;
    logic [W-1:0] w_res;
    logic [2:0]   w_flags;

    assign w_shifted = r_s1_vec >> r_s1_dsh;
    assign w_mask    = (V_ONE << r_s1_dsh) - V_ONE;
    assign w_mag     = w_shifted[W+1:2];
    assign w_guard   = w_shifted[1];
    assign w_sticky  = w_shifted[0] | (|(r_s1_vec & w_mask));
    assign w_inc     = (r_s1_mode == RND_RNE) & w_guard & (w_sticky | w_mag[0]);
    assign w_mag_r   = {1'b0, w_mag} + {{W{1'b0}}, w_inc};
    // Negative side reaches one further: -2^(W-1) is representable
    assign w_rnd_ovf = r_s1_sign ? (w_mag_r > NEG_LIM) : (w_mag_r > POS_LIM);

    always_comb begin
        w_res   = '0;
        w_flags = '0;
        case (r_s1_kind)
            K_NAN: w_flags[FLAG_INV] = 1'b1;
            K_INF: begin
                w_res              = r_s1_sign ? SAT_NEG : SAT_POS;
                w_flags[FLAG_INV]  = 1'b1;
                w_flags[FLAG_OVF]  = 1'b1;
            end
            K_OVF: begin
                w_res             = r_s1_sign ? SAT_NEG : SAT_POS;
                w_flags[FLAG_OVF] = 1'b1;
            end
            K_NORM: begin
                if (w_rnd_ovf) begin
                    w_res             = r_s1_sign ? SAT_NEG : SAT_POS;
                    w_flags[FLAG_OVF] = 1'b1;
                end else begin
                    w_res = r_s1_sign ? (-w_mag_r[W-1:0]) : w_mag_r[W-1:0];
                    if (w_mag_r == '0) w_flags[FLAG_UNF] = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_fx        <= '0;
            r_flags     <= '0;
        end else if (w_s1_adv) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_fx    <= w_res;
                r_flags <= w_flags;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)                           r_sticky <= '0;
        else if (r_out_valid && out_ready) r_sticky <= flags_clr ? r_flags : (r_sticky | r_flags);
        else if (flags_clr)                r_sticky <= '0;
    end

    assign out_valid    = r_out_valid;
    assign fx_out       = r_fx;
    assign flags        = r_flags;
    assign sticky_flags = r_sticky;
endmodule

// File: tb/tb_fp_to_fixed_pipe.sv
// tb/tb_fp_to_fixed_pipe.sv - self-checking bench: directed vectors plus randomized stream against a reference model
module tb_fp_to_fixed_pipe;
    localparam int Q = 2;
    localparam int F = 16;
    localparam int W = Q + F;
    localparam int N_RND = 400;

    logic         clk, rst, in_valid, in_ready, rnd_mode, out_valid, out_ready, flags_clr;
    logic [31:0]  fp_in;
    logic [W-1:0] fx_out;
    logic [2:0]   flags, sticky_flags;

    int n_chk = 0;
    int n_err = 0;

    fp_to_fixed_pipe #(.Q(Q), .F(F)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .fp_in        (fp_in),
        .rnd_mode     (rnd_mode),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .fx_out       (fx_out),
        .flags        (flags),
        .sticky_flags (sticky_flags),
        .flags_clr    (flags_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Exact value is mant * 2^(eu-23) ; scaled by 2^F and rounded with integer division
    function automatic void model(input logic [31:0] fp, input logic mode,
                                  output logic [W-1:0] res, output logic [2:0] fl);
        longint mant, mag, q, rem, half, maxpos, maxneg;
        int     eu, k, r;
        logic   s;
        s      = fp[31];
        maxpos = (longint'(1) << (W-1)) - 1;
        maxneg = longint'(1) << (W-1);
        fl     = 3'b000;
        res    = '0;
        if (fp[30:23] == 8'hFF) begin
            fl[0] = 1'b1;
            if (fp[22:0] == 23'd0) begin
                fl[1] = 1'b1;
                res   = s ? W'(-maxneg) : W'(maxpos);
            end
            return;
        end
        if (fp[30:0] == 31'd0) return;
        mant = {40'd0, (fp[30:23] != 8'd0), fp[22:0]};
        eu   = (fp[30:23] != 8'd0) ? int'(fp[30:23]) - 127 : -126;
        k    = eu - 23 + F;
        if (k >= 0) begin
            mag = (k > 30) ? (longint'(1) << 62) : (mant << k);
        end else begin
            r = -k;
            if (r > 40) begin
                mag = 0;
            end else begin
                q    = mant >> r;
                rem  = mant - (q << r);
                half = longint'(1) << (r - 1);
                if (mode && (rem > half || (rem == half && q[0]))) q++;
                mag = q;
            end
        end
        if (!s && mag > maxpos) begin
            res = W'(maxpos); fl[1] = 1'b1;
        end else if (s && mag > maxneg) begin
            res = W'(-maxneg); fl[1] = 1'b1;
        end else begin
            res = s ? W'(-mag) : W'(mag);
            if (mag == 0) fl[2] = 1'b1;
        end
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [31:0] v;
        v = $urandom;
        case ($urandom_range(0, 9))
            0: ;
            1: v[30:23] = 8'h00;
            2: begin
                v[30:23] = 8'hFF;
                if ($urandom_range(0, 1) == 1) v[22:0] = '0;
            end
            3: begin
                v[30:23] = 8'($urandom_range(108, 130));
                v[5:0]   = '0;
            end
            4: v[30:0] = '0;
            default: v[30:23] = 8'($urandom_range(108, 130));
        endcase
        return v;
    endfunction

    task automatic one(input string tag, input logic [31:0] fp, input logic mode,
                       input logic [31:0] ex_fx, input logic [2:0] ex_fl, input logic clr_hs);
        in_valid = 1'b1; fp_in = fp; rnd_mode = mode; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        chk({tag, ".valid"}, 32'(out_valid), 32'd1);
        chk({tag, ".fx"},    32'(fx_out),    ex_fx);
        chk({tag, ".flags"}, 32'(flags),     32'(ex_fl));
        flags_clr = clr_hs;
        step();
        flags_clr = 1'b0;
    endtask

    logic [31:0]  bp_in  [4];
    logic [31:0]  bp_exp [4];
    logic [W-1:0] bp_out [4];
    logic [W+2:0] exp_q [$];
    logic [W-1:0] m_res;
    logic [2:0]   m_fl, m_sticky;

    initial begin
        int n_acc, n_out, sent, got, cyc, stale;
        bp_in  = '{32'h3F800000, 32'h3FC00000, 32'hBF800000, 32'h3F000000};
        bp_exp = '{32'h10000, 32'h18000, 32'h30000, 32'h08000};
        rst = 1'b1; in_valid = 1'b1; fp_in = 32'h3F800000; rnd_mode = 1'b0;
        out_ready = 1'b1; flags_clr = 1'b0;
        step();
        step();
        chk("rst.valid",  32'(out_valid),    32'd0);
        chk("rst.fx",     32'(fx_out),       32'd0);
        chk("rst.flags",  32'(flags),        32'd0);
        chk("rst.sticky", 32'(sticky_flags), 32'd0);
        rst = 1'b0; in_valid = 1'b0;
        #1;
        chk("rst.in_ready", 32'(in_ready), 32'd1);

        in_valid = 1'b1; fp_in = 32'h3F800000;
        step();
        fp_in = 32'h3FC00000;
        step();
        fp_in = 32'hBF800000;
        chk("b2b.0.valid", 32'(out_valid), 32'd1);
        chk("b2b.0.fx",    32'(fx_out),    32'h10000);
        chk("b2b.0.flags", 32'(flags),     32'd0);
        step();
        in_valid = 1'b0;
        chk("b2b.1.fx",    32'(fx_out), 32'h18000);
        chk("b2b.1.flags", 32'(flags),  32'd0);
        step();
        chk("b2b.2.fx",    32'(fx_out), 32'h30000);
        chk("b2b.2.flags", 32'(flags),  32'd0);
        step();

        one("pos2",   32'h40000000, 1'b0, 32'h1FFFF, 3'b010, 1'b0);
        one("neg2",   32'hC0000000, 1'b0, 32'h20000, 3'b000, 1'b0);
        one("ninf",   32'hFF800000, 1'b0, 32'h20000, 3'b011, 1'b0);
        one("nan",    32'h7FC00000, 1'b0, 32'h00000, 3'b001, 1'b0);
        one("half0",  32'h37000000, 1'b0, 32'h00000, 3'b100, 1'b0);
        one("half1",  32'h37000000, 1'b1, 32'h00000, 3'b100, 1'b0);
        one("above0", 32'h37400000, 1'b0, 32'h00000, 3'b100, 1'b0);
        one("above1", 32'h37400000, 1'b1, 32'h00001, 3'b000, 1'b0);

        flags_clr = 1'b1;
        step();
        flags_clr = 1'b0;
        chk("sticky.clr", 32'(sticky_flags), 32'd0);
        one("stk.nan", 32'h7FC00000, 1'b0, 32'h00000, 3'b001, 1'b0);
        one("stk.ovf", 32'h40000000, 1'b0, 32'h1FFFF, 3'b010, 1'b0);
        chk("sticky.or", 32'(sticky_flags), 32'b011);
        one("stk.unf", 32'h37000000, 1'b0, 32'h00000, 3'b100, 1'b1);
        chk("sticky.setwins", 32'(sticky_flags), 32'b100);

        n_acc = 0; n_out = 0; rnd_mode = 1'b0;
        for (int c = 0; c < 30 && n_out < 4; c++) begin
            out_ready = (c >= 5);
            in_valid  = (n_acc < 4);
            fp_in     = bp_in[(n_acc < 4) ? n_acc : 3];
            #2;
            if (c == 2) begin
                chk("bp.in_ready", 32'(in_ready), 32'd0);
                chk("bp.accepts",  32'(n_acc),    32'd2);
            end
            if (c >= 2 && c <= 4) begin
                chk("bp.hold.valid", 32'(out_valid), 32'd1);
                chk("bp.hold.fx",    32'(fx_out),    32'h10000);
            end
            if (out_valid && out_ready) begin
                bp_out[n_out] = fx_out;
                n_out++;
            end
            if (in_valid && in_ready) n_acc++;
            step();
        end
        in_valid = 1'b0;
        chk("bp.count", 32'(n_out), 32'd4);
        for (int i = 0; i < 4; i++) chk($sformatf("bp.out%0d", i), 32'(bp_out[i]), bp_exp[i]);

        out_ready = 1'b1; in_valid = 1'b1; fp_in = 32'h40000000;
        step();
        fp_in = 32'h3F800000;
        step();
        rst = 1'b1; fp_in = 32'h3FC00000;
        step();
        chk("mrst.valid",  32'(out_valid),    32'd0);
        chk("mrst.sticky", 32'(sticky_flags), 32'd0);
        chk("mrst.fx",     32'(fx_out),       32'd0);
        step();
        rst = 1'b0; in_valid = 1'b0;
        #1;
        chk("mrst.in_ready", 32'(in_ready), 32'd1);
        stale = 0;
        repeat (6) begin
            step();
            if (out_valid) stale++;
        end
        chk("mrst.stale", 32'(stale), 32'd0);

        flags_clr = 1'b1;
        step();
        flags_clr = 1'b0;
        m_sticky = 3'b000;
        sent = 0; got = 0; cyc = 0;
        while (got < N_RND && cyc < 20000) begin
            in_valid  = (sent < N_RND) && ($urandom_range(0, 9) < 7);
            fp_in     = rand_fp();
            rnd_mode  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 9) < 7);
            flags_clr = ($urandom_range(0, 19) == 0);
            #2;
            chk("rnd.sticky", 32'(sticky_flags), 32'(m_sticky));
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("rnd.unexpected", 32'(out_valid), 32'd0);
                end else begin
                    chk("rnd.fx",    32'(fx_out), 32'(exp_q[0][W-1:0]));
                    chk("rnd.flags", 32'(flags),  32'(exp_q[0][W+2:W]));
                    if (out_ready) begin
                        m_sticky = flags_clr ? exp_q[0][W+2:W] : (m_sticky | exp_q[0][W+2:W]);
                        void'(exp_q.pop_front());
                        got++;
                    end
                end
            end
            if (!(out_valid && out_ready) && flags_clr) m_sticky = 3'b000;
            if (in_valid && in_ready) begin
                model(fp_in, rnd_mode, m_res, m_fl);
                exp_q.push_back({m_fl, m_res});
                sent++;
            end
            step();
            cyc++;
        end
        in_valid = 1'b0; flags_clr = 1'b0;
        chk("rnd.count", 32'(got), 32'(N_RND));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
